// File: rtl/std_arb_pkg.sv
// Shared types and limits for the round-robin arbiter family.
package std_arb_pkg;

  typedef enum logic {
    ARB_FREE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned MaxNumReq = 16;

endpackage

// File: rtl/DFFR.sv
// Generic W-bit flop with asynchronous active-low reset to zero.
module DFFR #(
  parameter int unsigned W = 1
) (
  input  logic         CLK,
  input  logic         RSTN,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) o_q <= '0;
    else       o_q <= i_d;
  end

endmodule

// File: rtl/std_rr_pick.sv
// Rotating priority pick: first set request at or above i_ptr, wrapping.
module std_rr_pick #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdW    = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] i_req,
  input  logic [IdW-1:0]    i_ptr,
  output logic [NumReq-1:0] o_gnt_c,
  output logic              o_found_c
);

  int unsigned w_idx;

  always_comb begin
    o_gnt_c   = '0;
    o_found_c = 1'b0;
    w_idx     = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      w_idx = (32'(i_ptr) + k) % NumReq;
      if (!o_found_c && i_req[IdW'(w_idx)]) begin
        o_gnt_c[IdW'(w_idx)] = 1'b1;
        o_found_c            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/std_rr_arbiter.sv
// Round-robin arbiter feeding a one-entry registered output slot.
// Define STD_ARB_LOCK_EN to keep multi-beat packets contiguous on the output.
module std_rr_arbiter
  import std_arb_pkg::*;
#(
  parameter int unsigned NumReq = 4,
  parameter int unsigned Width  = 8,
  parameter int unsigned IdW    = $clog2(NumReq)
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic [NumReq-1:0]       req_valid,
  input  logic [NumReq-1:0]       req_last,
  input  logic [NumReq*Width-1:0] req_data,
  output logic [NumReq-1:0]       req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [Width-1:0]        out_data,
  output logic                    out_last,
  output logic [IdW-1:0]          out_id
);

  if (NumReq < 2 || NumReq > MaxNumReq) begin : g_bad_numreq
    $error("std_rr_arbiter: NumReq out of range");
  end

  logic              r_out_valid, w_out_valid_nxt;
  logic [Width-1:0]  r_out_data,  w_out_data_nxt;
  logic              r_out_last,  w_out_last_nxt;
  logic [IdW-1:0]    r_out_id,    w_out_id_nxt;
  logic [IdW-1:0]    r_ptr,       w_ptr_nxt;

  logic [NumReq-1:0] w_eligible;
  logic [NumReq-1:0] w_gnt;
  logic              w_found;
  logic              w_slot_free;
  logic              w_accept;
  logic              w_ptr_upd;
  logic [IdW-1:0]    w_win_idx;
  logic [Width-1:0]  w_win_data;
  logic              w_win_last;

  std_rr_pick #(.NumReq(NumReq), .IdW(IdW)) u_pick (
    .i_req     (w_eligible),
    .i_ptr     (r_ptr),
    .o_gnt_c   (w_gnt),
    .o_found_c (w_found)
  );

  // Free slot admits a beat even while the current one leaves.
  assign w_slot_free = !r_out_valid || out_ready;
  assign w_accept    = w_found && w_slot_free;
  assign req_ready   = w_slot_free ? w_gnt : '0;

  always_comb begin
    w_win_idx  = '0;
    w_win_data = '0;
    w_win_last = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (w_gnt[i]) begin
        w_win_idx  = IdW'(i);
        w_win_data = req_data[i*Width +: Width];
        w_win_last = req_last[i];
      end
    end
  end

  always_comb begin
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_out_last_nxt  = r_out_last;
    w_out_id_nxt    = r_out_id;
    if (w_accept) begin
      w_out_valid_nxt = 1'b1;
      w_out_data_nxt  = w_win_data;
      w_out_last_nxt  = w_win_last;
      w_out_id_nxt    = w_win_idx;
    end else if (r_out_valid && out_ready) begin
      w_out_valid_nxt = 1'b0;
    end
  end

  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_ptr_upd) begin
      w_ptr_nxt = (32'(w_win_idx) == NumReq - 1) ? '0 : w_win_idx + IdW'(1);
    end
  end

`ifdef STD_ARB_LOCK_EN
  logic [0:0]        w_state_q;
  arb_state_e        r_state, w_state_nxt;
  logic [IdW-1:0]    r_owner, w_owner_nxt;
  logic [NumReq-1:0] w_owner_mask;

  assign r_state   = arb_state_e'(w_state_q);
  assign w_ptr_upd = w_accept && w_win_last;

  // While locked only the packet owner may compete, even when idle.
  always_comb begin
    w_owner_mask = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      w_owner_mask[i] = (r_owner == IdW'(i));
    end
    w_eligible = req_valid;
    if (r_state == ARB_LOCKED) w_eligible = req_valid & w_owner_mask;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    case (r_state)
      ARB_FREE: begin
        if (w_accept && !w_win_last) begin
          w_state_nxt = ARB_LOCKED;
          w_owner_nxt = w_win_idx;
        end
      end
      ARB_LOCKED: begin
        if (w_accept && w_win_last) w_state_nxt = ARB_FREE;
      end
      default: w_state_nxt = ARB_FREE;
    endcase
  end

  DFFR #(.W(1))   u_state (.CLK(CLK), .RSTN(RSTN), .i_d(1'(w_state_nxt)), .o_q(w_state_q));
  DFFR #(.W(IdW)) u_owner (.CLK(CLK), .RSTN(RSTN), .i_d(w_owner_nxt),     .o_q(r_owner));
`else
  assign w_eligible = req_valid;
  assign w_ptr_upd  = w_accept;
`endif

  DFFR #(.W(1))     u_valid (.CLK(CLK), .RSTN(RSTN), .i_d(w_out_valid_nxt), .o_q(r_out_valid));
  DFFR #(.W(Width)) u_data  (.CLK(CLK), .RSTN(RSTN), .i_d(w_out_data_nxt),  .o_q(r_out_data));
  DFFR #(.W(1))     u_last  (.CLK(CLK), .RSTN(RSTN), .i_d(w_out_last_nxt),  .o_q(r_out_last));
  DFFR #(.W(IdW))   u_id    (.CLK(CLK), .RSTN(RSTN), .i_d(w_out_id_nxt),    .o_q(r_out_id));
  DFFR #(.W(IdW))   u_ptr   (.CLK(CLK), .RSTN(RSTN), .i_d(w_ptr_nxt),       .o_q(r_ptr));

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_id    = r_out_id;

endmodule

// File: tb/tb_std_rr_arbiter.sv
// Scoreboard bench for std_rr_arbiter (default 4 requesters x 8 bits).
module tb_std_rr_arbiter;
  import std_arb_pkg::*;

  localparam int unsigned NumReq = 4;
  localparam int unsigned Width  = 8;
  localparam int unsigned IdW    = 2;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [Width-1:0] data;
    logic             last;
  } beat_t;

  logic                    CLK = 1'b0;
  logic                    RSTN;
  logic [NumReq-1:0]       req_valid;
  logic [NumReq-1:0]       req_last;
  logic [NumReq*Width-1:0] req_data;
  logic [NumReq-1:0]       req_ready;
  logic                    out_valid;
  logic                    out_ready;
  logic [Width-1:0]        out_data;
  logic                    out_last;
  logic [IdW-1:0]          out_id;

  beat_t       exp_q[$];
  logic [8:0]  bm[NumReq][8];
  int unsigned hd[NumReq];
  int unsigned tl[NumReq];
  int          n_chk = 0;
  int          n_fail = 0;

  std_rr_arbiter #(.NumReq(NumReq), .Width(Width)) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_id    (out_id)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_beat(input int r, input logic [7:0] d, input logic l);
    bm[r][tl[r]] = {l, d};
    tl[r]++;
  endtask

  task automatic push_exp(input int id, input logic [7:0] d, input logic l);
    beat_t e;
    e.id   = IdW'(id);
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NumReq; i++) begin
      if (hd[i] != tl[i]) begin
        req_valid[i]                = 1'b1;
        req_data[i*Width +: Width]  = bm[i][hd[i]][7:0];
        req_last[i]                 = bm[i][hd[i]][8];
      end else begin
        req_valid[i]                = 1'b0;
        req_data[i*Width +: Width]  = '0;
        req_last[i]                 = 1'b0;
      end
    end
  endtask

  task automatic flush();
    for (int i = 0; i < NumReq; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    exp_q.delete();
    drive_reqs();
  endtask

  task automatic wait_drain(input string name);
    bool_loop: for (int c = 0; c < 60; c++) begin
      @(negedge CLK);
      if (exp_q.size() == 0 && !out_valid && req_valid == '0) begin
        n_chk++;
        return;
      end
    end
    n_chk++;
    n_fail++;
    $display("FAIL %s: drain timeout, %0d beats still expected, out_valid=%0b", name, exp_q.size(), out_valid);
  endtask

  // Requester model: advance to the next beat after each accepted handshake.
  initial begin
    logic [NumReq-1:0] fire;
    forever begin
      @(negedge CLK);
      fire = req_valid & req_ready;
      @(posedge CLK);
      #1;
      for (int i = 0; i < NumReq; i++) begin
        if (fire[i] && hd[i] != tl[i]) hd[i]++;
      end
      drive_reqs();
    end
  end

  // Monitor: each beat leaving the slot is compared against the scoreboard.
  always @(negedge CLK) begin
    beat_t e;
    if (RSTN === 1'b1 && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected: got id=%0d data=0x%0h, expected no beat", out_id, out_data);
      end else begin
        e = exp_q.pop_front();
        check("sb_id",   32'(out_id),   32'(e.id));
        check("sb_data", 32'(out_data), 32'(e.data));
        check("sb_last", 32'(out_last), 32'(e.last));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RSTN      = 1'b0;
    out_ready = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    flush();
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_out_id",    32'(out_id),    32'd0);
    check("rst_ptr",       32'(dut.r_ptr), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    out_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #3 RSTN = 1'b1;

    // Basic pass-through
    @(negedge CLK);
    push_beat(0, 8'h11, 1'b1);
    push_exp(0, 8'h11, 1'b1);
    @(negedge CLK);
    check("basic_req_ready", 32'(req_ready), 32'h1);
    @(negedge CLK);
    check("basic_out_valid", 32'(out_valid), 32'd1);
    check("basic_out_data",  32'(out_data),  32'h11);
    check("basic_out_id",    32'(out_id),    32'd0);
    check("basic_ptr",       32'(dut.r_ptr), 32'd1);
    wait_drain("basic_drain");

    // Rotation from a fresh pointer
    @(posedge CLK);
    #3 RSTN = 1'b0;
    flush();
    @(posedge CLK);
    #3 RSTN = 1'b1;
    @(negedge CLK);
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < NumReq; i++) begin
        push_beat(i, 8'(16 * i + b), 1'b1);
        push_exp(i, 8'(16 * i + b), 1'b1);
      end
    end
    repeat (2) @(negedge CLK);
    for (int k = 0; k < 5; k++) begin
      check("rot_out_valid", 32'(out_valid), 32'd1);
      check("rot_out_id",    32'(out_id),    32'(k % 4));
      @(negedge CLK);
    end
    wait_drain("rot_drain");

    // Backpressure then release with no bubble
    @(posedge CLK);
    #1 out_ready = 1'b0;
    @(negedge CLK);
    push_beat(1, 8'hA1, 1'b1);
    push_beat(1, 8'hB1, 1'b1);
    push_beat(2, 8'hC2, 1'b1);
    push_exp(1, 8'hA1, 1'b1);
    push_exp(2, 8'hC2, 1'b1);
    push_exp(1, 8'hB1, 1'b1);
    repeat (4) @(negedge CLK);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_out_data",  32'(out_data),  32'hA1);
    check("bp_out_id",    32'(out_id),    32'd1);
    check("bp_req_ready", 32'(req_ready), 32'h0);
    @(negedge CLK);
    check("bp_data_stable", 32'(out_data), 32'hA1);
    @(posedge CLK);
    #1 out_ready = 1'b1;
    @(negedge CLK);
    check("bp_release_ready", 32'(req_ready), 32'h4);
    @(negedge CLK);
    check("bp_nobubble_valid", 32'(out_valid), 32'd1);
    check("bp_nobubble_id",    32'(out_id),    32'd2);
    check("bp_nobubble_data",  32'(out_data),  32'hC2);
    wait_drain("bp_drain");
    check("bp_ptr", 32'(dut.r_ptr), 32'd2);

    // Packet from requester 2 competing with requester 0
    @(negedge CLK);
    push_beat(2, 8'h21, 1'b0);
    push_beat(2, 8'h22, 1'b0);
    push_beat(2, 8'h23, 1'b1);
    push_beat(0, 8'h01, 1'b1);
    push_beat(0, 8'h02, 1'b1);
`ifdef STD_ARB_LOCK_EN
    push_exp(2, 8'h21, 1'b0);
    push_exp(2, 8'h22, 1'b0);
    push_exp(2, 8'h23, 1'b1);
    push_exp(0, 8'h01, 1'b1);
    push_exp(0, 8'h02, 1'b1);
`else
    push_exp(2, 8'h21, 1'b0);
    push_exp(0, 8'h01, 1'b1);
    push_exp(2, 8'h22, 1'b0);
    push_exp(0, 8'h02, 1'b1);
    push_exp(2, 8'h23, 1'b1);
`endif
    @(negedge CLK);
    check("pkt_ready_1", 32'(req_ready), 32'h4);
    @(negedge CLK);
`ifdef STD_ARB_LOCK_EN
    check("pkt_ready_2", 32'(req_ready), 32'h4);
`else
    check("pkt_ready_2", 32'(req_ready), 32'h1);
`endif
    @(negedge CLK);
    check("pkt_ready_3", 32'(req_ready), 32'h4);
    wait_drain("pkt_drain");

    // Reset in the middle of a packet with the slot full
    @(posedge CLK);
    #1 out_ready = 1'b0;
    @(negedge CLK);
    push_beat(1, 8'h41, 1'b0);
    push_beat(1, 8'h42, 1'b0);
    push_beat(1, 8'h43, 1'b1);
    repeat (3) @(negedge CLK);
    check("mid_out_valid", 32'(out_valid), 32'd1);
    check("mid_out_id",    32'(out_id),    32'd1);
`ifdef STD_ARB_LOCK_EN
    check("mid_state", 32'(dut.r_state), 32'(ARB_LOCKED));
`endif
    @(posedge CLK);
    #3 RSTN = 1'b0;
    flush();
    #1;
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_out_data",  32'(out_data),  32'd0);
    check("mrst_out_last",  32'(out_last),  32'd0);
    check("mrst_out_id",    32'(out_id),    32'd0);
    check("mrst_ptr",       32'(dut.r_ptr), 32'd0);
    check("mrst_req_ready", 32'(req_ready), 32'd0);
`ifdef STD_ARB_LOCK_EN
    check("mrst_state", 32'(dut.r_state), 32'(ARB_FREE));
`endif
    out_ready = 1'b1;
    @(posedge CLK);
    #3 RSTN = 1'b1;
    @(negedge CLK);
    push_beat(0, 8'h05, 1'b1);
    push_beat(2, 8'h07, 1'b1);
    push_exp(0, 8'h05, 1'b1);
    push_exp(2, 8'h07, 1'b1);
    @(negedge CLK);
    check("post_rst_ready", 32'(req_ready), 32'h1);
    wait_drain("post_rst_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/std_rr_arbiter.md
# std_rr_arbiter

Round-robin arbiter that shares one registered output channel among `NumReq` valid/ready requesters. It sits in front of any single-port resource in the NoC (a router output port, a shared DFF-based pipeline stage). It picks one requester per cycle from a rotating priority pointer and registers the winning beat into a one-entry output slot. The slot is built from asynchronous-reset flops and its contents are fully defined after reset.

## Interface
Parameters:
- `NumReq`, default 4, number of requesters; range 2..16.
- `Width`, default 8, payload width in bits.
- `IdW`, default `$clog2(NumReq)`, width of the grant index. Derived; must not be overridden.

Ports:
- `CLK`, input, 1, clock.
- `RSTN`, input, 1, reset, asynchronous, active-low.
- `req_valid`, input, `NumReq`, per-requester beat valid.
- `req_last`, input, `NumReq`, per-requester last-beat-of-packet flag.
- `req_data`, input, `NumReq*Width`, per-requester payload. Requester i occupies bits `[i*Width +: Width]`.
- `req_ready`, output, `NumReq`, per-requester accept. One-hot or zero.
- `out_valid`, output, 1, output slot holds a beat.
- `out_ready`, input, 1, downstream accepts the beat.
- `out_data`, output, `Width`, registered payload.
- `out_last`, output, 1, registered last flag.
- `out_id`, output, `IdW`, index of the requester that supplied the beat.

## Operation
- **Handshake.** A transfer happens when valid and ready are both high on a rising `CLK`. A requester may not drop `req_valid` or change `req_data`/`req_last` until its beat is accepted. Downstream obeys the same rule on the output.
- **Slot free.** The slot is free when `out_valid`=0 or `out_ready`=1. This allows back-to-back enqueue and dequeue in the same cycle.
- **Winner selection.**
  - Winner = first asserted `req_valid` found scanning upward from `ptr`, wrapping modulo `NumReq`.
  - `req_ready[winner]`=1 only when the slot is free; every other `req_ready` bit is 0.
- **On accept.**
  - The slot loads data, last and id; `out_valid`=1.
  - `ptr` <= (winner+1) mod `NumReq`. When lock is enabled, `ptr` updates only on accept of a beat with `req_last`=1.
- **Dequeue without enqueue.** On `out_valid`&`out_ready` with no accept in the same cycle, `out_valid` <= 0.
- **No requests.** `ptr` holds; `req_ready`=0.
- **Lock FSM** (when enabled): states `ARB_FREE` and `ARB_LOCKED`.
  - FREE -> LOCKED on accept with `req_last`=0; the lock owner is latched.
  - LOCKED -> FREE on accept from the owner with `req_last`=1.
  - In LOCKED, only the owner is eligible. Other requesters see `req_ready`=0 even if the owner is idle.
- **Reset (any time, including mid-packet).** `out_valid`=0, `out_data`=0, `out_last`=0, `out_id`=0, `ptr`=0, state=`ARB_FREE`. Any in-flight beat is discarded.

## Timing
- Latency is 1 cycle: a beat accepted at edge k is visible on `out_*` after edge k.
- Throughput is 1 beat/cycle while `out_ready`=1.
- `req_ready` is combinational from `req_valid`, `out_valid`, `out_ready`, `ptr` and the lock state. There is no combinational path from `req_data` to any output.
- `out_*` are driven directly from flops.
- Starvation bound: a continuously valid requester is granted within `NumReq`-1 competing packets.

## Configuration
- `STD_ARB_LOCK_EN` defined: the lock FSM is compiled in and packets are never interleaved on the output.
- Not defined:
  - Every beat is arbitrated independently and `ptr` advances on every accept.
  - `req_last` is only carried through to `out_last`.
  - No lock state exists.

## Structure
- Shared package `std_arb_pkg` holds:
  - The state typedef `arb_state_e` {`ARB_FREE`, `ARB_LOCKED`}.
  - The maximum `NumReq` constant (16).
- Sub-module `std_rr_pick`: combinational rotate-and-priority-encode. Inputs are the request mask and `ptr`; outputs are a one-hot grant and a found flag.
- All state (slot, `ptr`, lock state, owner) uses `DFFR` instances with zero reset values.

## Test plan
- **Basic pass-through.** Reset, then `req_valid`=4'b0001 with data 0x11 and `out_ready`=1 -> next cycle `out_valid`=1, `out_data`=0x11, `out_id`=0, `ptr`=1.
- **Rotation.** All four valid, single-beat, `out_ready`=1 -> `out_id` sequence 0,1,2,3,0 on consecutive cycles.
- **Backpressure.** Hold `out_ready`=0 with the slot full -> `req_ready`=0 and `out_data` stable. Raise `out_ready` -> a new beat loads in the same cycle with no bubble.
- **Lock (macro on).** Requester 2 sends beats last=0,0,1 while requester 0 is valid -> `out_id`=2,2,2, then 0. Requester 0's `req_ready` stays 0 during the packet.
- **Lock off.** Same stimulus as the lock test -> output alternates `out_id` 2,0,2,0,2.
- **Reset mid-packet.** Assert RSTN=0 while LOCKED with `out_valid`=1 -> all outputs 0 immediately, state `ARB_FREE`, and the first grant after release goes to requester 0.
